// File: rtl/t02_pkg.sv
// Shared types and encodings for the t02 load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t02_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // True when the access cannot be issued: unsupported funct3 or an
   // address that is not naturally aligned for the access size.
   function automatic logic access_bad(input logic       is_load,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
      logic illegal;
      logic misaligned;
      if (is_load)
         illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      else
         illegal = f3[2] || (f3 == 3'b011);
      misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                   ((f3[1:0] == 2'b10) && (off != 2'b00));
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/t02_load_align.sv
// Extracts and sign/zero-extends the addressed byte/half/word of a bus read word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module t02_load_align
   import t02_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane select by byte offset, then extend according to funct3.
   always_comb begin
      byte_v = rdata_i[8*offset_i +: 8];
      half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
         F3_H:    data_o = {{16{half_v[15]}}, half_v};
         F3_BU:   data_o = {24'd0, byte_v};
         F3_HU:   data_o = {16'd0, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/t02_load_store_unit.sv
// Memory stage: issues one request/ack bus access per load/store, writes load data back.
// Latency: IDLE -> BUS (>=1 cycle, until ack or timeout) -> DONE; 3 cycles on a zero-wait bus.
// Backpressure: stall is held from the accepting IDLE cycle through the last BUS cycle.
module t02_load_store_unit
   import t02_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        nRST,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_read,
   output logic        bus_write,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_sel,
   output logic        stall,
   output logic        rf_write,
   output logic [4:0]  rf_index,
   output logic [31:0] rf_data,
   output logic        lsu_fault
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] sdata_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_q;
   logic        is_load_q;
   logic        abort_q;
   logic [31:0] ldata_q;

   logic        req;
   logic        bad;
   logic        take;
   logic [31:0] ldata_d;
   logic [3:0]  sel_v;
   logic [31:0] wdata_v;
   logic        in_idle;
   logic        in_bus;
   logic        in_done;

   // A simultaneous load+store is resolved as a load.
   assign req  = load | store;
   assign bad  = access_bad(load, funct3, addr[1:0]);
   assign take = req & ~bad;

   assign in_idle = (state_q == IDLE);
   assign in_bus  = (state_q == BUS);
   assign in_done = (state_q == DONE);

   t02_load_align u_align (
      .rdata_i  (bus_rdata),
      .offset_i (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (ldata_d)
   );

   // Access FSM: capture in IDLE, wait for ack or timeout in BUS, one-cycle DONE.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         addr_q    <= 32'd0;
         sdata_q   <= 32'd0;
         f3_q      <= 3'd0;
         rd_q      <= 5'd0;
         is_load_q <= 1'b0;
         abort_q   <= 1'b0;
         ldata_q   <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (take) begin
                  addr_q    <= addr;
                  sdata_q   <= store_data;
                  f3_q      <= funct3;
                  rd_q      <= rd;
                  is_load_q <= load;
                  abort_q   <= 1'b0;
                  cnt_q     <= 8'd0;
                  state_q   <= BUS;
               end
            end
            BUS: begin
               // An ack in the expiry cycle still wins over the abort.
               if (bus_ack) begin
                  if (is_load_q)
                     ldata_q <= ldata_d;
                  state_q <= DONE;
               end else if (cnt_q == CNT_LAST) begin
                  abort_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Store lane steering from the captured access; loads read the full word.
   always_comb begin
      sel_v   = 4'b1111;
      wdata_v = 32'd0;
      if (!is_load_q) begin
         case (f3_q[1:0])
            2'b00: begin
               sel_v   = 4'b0001 << addr_q[1:0];
               wdata_v = {4{sdata_q[7:0]}};
            end
            2'b01: begin
               sel_v   = addr_q[1] ? 4'b1100 : 4'b0011;
               wdata_v = {2{sdata_q[15:0]}};
            end
            default: begin
               sel_v   = 4'b1111;
               wdata_v = sdata_q;
            end
         endcase
      end
   end

   // Bus signals only during BUS; IDLE-cycle responses are gated so reset forces all zero.
   always_comb begin
      bus_read  = in_bus & is_load_q;
      bus_write = in_bus & ~is_load_q;
      bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
      bus_sel   = in_bus ? sel_v : 4'd0;
      bus_wdata = in_bus ? wdata_v : 32'd0;
      stall     = nRST & ((in_idle & take) | in_bus);
      lsu_fault = nRST & ((in_idle & req & bad) | (in_done & abort_q));
      rf_write  = in_done & ~abort_q & is_load_q & (rd_q != 5'd0);
      rf_index  = rf_write ? rd_q : 5'd0;
      rf_data   = rf_write ? ldata_q : 32'd0;
   end

endmodule

// File: tb/tb_t02_load_store_unit.sv
module tb_t02_load_store_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        nRST;
   logic        load, store;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [4:0]  rd;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_read, bus_write;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_sel;
   logic        stall, rf_write;
   logic [4:0]  rf_index;
   logic [31:0] rf_data;
   logic        lsu_fault;

   int checks   = 0;
   int failures = 0;

   t02_load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .nRST(nRST), .load(load), .store(store), .funct3(funct3),
      .addr(addr), .store_data(store_data), .rd(rd), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata), .bus_read(bus_read), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
      .stall(stall), .rf_write(rf_write), .rf_index(rf_index),
      .rf_data(rf_data), .lsu_fault(lsu_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          stall_cyc;
      int          bus_cyc;
      int          rd_cyc;
      int          wr_cyc;
      int          rfw_total;
      int          fault_total;
      logic        fault_first;
      logic        fault_done;
      logic        rfw_done;
      logic [4:0]  idx;
      logic [31:0] data;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic [3:0]  bsel;
      logic        unstable;
      logic        timed_out;
   } obs_t;

   // ---------------- reference model (size/offset arithmetic) ----------------
   function automatic int m_bytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
      int n = m_bytes(f3);
      int o = int'(a % 4);
      return (o / n) * n;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rw);
      int     n = m_bytes(f3);
      longint v;
      v = (longint'(rw) >> (8 * m_off(f3, a))) % (longint'(1) << (8 * n));
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   function automatic logic [3:0] m_sel(input bit isld, input logic [2:0] f3,
                                        input logic [31:0] a);
      if (isld) return 4'hF;
      return 4'(((1 << m_bytes(f3)) - 1) << m_off(f3, a));
   endfunction

   function automatic logic [31:0] m_wdata(input bit isld, input logic [2:0] f3,
                                           input logic [31:0] sd);
      int     n = m_bytes(f3);
      longint w = 0;
      longint piece;
      if (isld) return 32'd0;
      piece = longint'(sd) % (longint'(1) << (8 * n));
      for (int i = 0; i < 4 / n; i++)
         w = w + (piece << (8 * n * i));
      return 32'(w);
   endfunction

   function automatic bit m_bad(input bit isld, input logic [2:0] f3, input logic [31:0] a);
      bit illegal, mis;
      int k = int'(f3);
      if (isld) illegal = (k == 3) || (k == 6) || (k == 7);
      else      illegal = (k >= 4) || (k == 3);
      mis = (m_bytes(f3) == 2 && (a % 2) != 0) || (m_bytes(f3) == 4 && (a % 4) != 0);
      return illegal || mis;
   endfunction

   // ---------------- driver / observer ----------------
   // ack_after: ack in the Nth BUS cycle (1-based); 0 means never.
   task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [4:0] r, input int ack_after,
                             input logic [31:0] rdat, output obs_t o);
      int cyc = 0;
      bit ended = 0;
      bit first_bus = 1;
      o = '{default: 0};
      @(posedge clk); #1;
      load = ld; store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
      bus_ack = 1'b0;
      while (!ended && cyc < 40) begin
         @(negedge clk);
         if (stall)     o.stall_cyc++;
         if (bus_read)  o.rd_cyc++;
         if (bus_write) o.wr_cyc++;
         if (rf_write)  o.rfw_total++;
         if (lsu_fault) o.fault_total++;
         if (bus_read || bus_write) begin
            o.bus_cyc++;
            if (first_bus) begin
               o.baddr = bus_addr; o.bsel = bus_sel; o.bwdata = bus_wdata;
               first_bus = 0;
            end else if (bus_addr !== o.baddr || bus_sel !== o.bsel || bus_wdata !== o.bwdata)
               o.unstable = 1'b1;
         end
         bus_ack   = 1'b0;
         bus_rdata = $urandom;
         if (cyc == 0) begin
            o.fault_first = lsu_fault;
            if (!stall) ended = 1;
         end else if (!stall) begin
            o.fault_done = lsu_fault; o.rfw_done = rf_write;
            o.idx = rf_index; o.data = rf_data;
            ended = 1;
         end else if ((bus_read || bus_write) && o.bus_cyc == ack_after) begin
            bus_ack = 1'b1; bus_rdata = rdat;
         end
         if (ended) begin load = 1'b0; store = 1'b0; end
         cyc++;
      end
      if (!ended) begin o.timed_out = 1'b1; load = 1'b0; store = 1'b0; bus_ack = 1'b0; end
      repeat (2) begin
         @(negedge clk);
         if (stall) o.stall_cyc++;
         if (bus_read || bus_write) o.bus_cyc++;
         if (rf_write)  o.rfw_total++;
         if (lsu_fault) o.fault_total++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      nRST = 1'b0;
      load = 1'b1; store = 1'b1; funct3 = 3'b010; addr = 32'h100;
      store_data = 32'h12345678; rd = 5'd5; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_read, bus_write, bus_addr, bus_wdata, bus_sel} !== '0) begin
         failures++;
         $display("FAIL reset_bus: got rd=%b wr=%b addr=%h wdata=%h sel=%b, want all 0",
                  bus_read, bus_write, bus_addr, bus_wdata, bus_sel);
      end
      checks++;
      if ({stall, rf_write, rf_index, rf_data, lsu_fault} !== '0) begin
         failures++;
         $display("FAIL reset_core: got stall=%b rfw=%b idx=%0d data=%h fault=%b, want all 0",
                  stall, rf_write, rf_index, rf_data, lsu_fault);
      end
      load = 1'b0; store = 1'b0; bus_ack = 1'b0;
      nRST = 1'b1;
      @(negedge clk);
      checks++;
      if ({stall, bus_read, bus_write, rf_write, lsu_fault} !== '0) begin
         failures++;
         $display("FAIL reset_idle: got %b, want 00000",
                  {stall, bus_read, bus_write, rf_write, lsu_fault});
      end
   endtask

   task automatic test_lw;
      obs_t o;
      run_access(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 2, 32'hDEADBEEF, o);
      checks++; if (o.baddr !== 32'h100) begin failures++; $display("FAIL lw_addr: got %h want 00000100", o.baddr); end
      checks++; if (o.rd_cyc != 2 || o.wr_cyc != 0) begin failures++; $display("FAIL lw_read_cycles: got rd=%0d wr=%0d want 2/0", o.rd_cyc, o.wr_cyc); end
      checks++; if (o.stall_cyc != 3) begin failures++; $display("FAIL lw_stall: got %0d want 3", o.stall_cyc); end
      checks++; if (o.rfw_done !== 1'b1 || o.idx !== 5'd5 || o.data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL lw_wb: got rfw=%b idx=%0d data=%h want 1/5/deadbeef", o.rfw_done, o.idx, o.data); end
      checks++; if (o.bsel !== 4'hF || o.fault_total != 0) begin failures++; $display("FAIL lw_sel_fault: got sel=%b faults=%0d want 1111/0", o.bsel, o.fault_total); end
   endtask

   task automatic test_load_ext;
      obs_t o;
      run_access(1, 0, 3'b000, 32'h203, 32'h0, 5'd7, 1, 32'h80FF1234, o);
      checks++; if (o.data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb: got %h want ffffff80", o.data); end
      checks++; if (o.stall_cyc != 2) begin failures++; $display("FAIL zero_wait_stall: got %0d want 2", o.stall_cyc); end
      run_access(1, 0, 3'b100, 32'h203, 32'h0, 5'd7, 1, 32'h80FF1234, o);
      checks++; if (o.data !== 32'h00000080) begin failures++; $display("FAIL lbu: got %h want 00000080", o.data); end
      run_access(1, 0, 3'b101, 32'h202, 32'h0, 5'd7, 1, 32'h80FF1234, o);
      checks++; if (o.data !== 32'h000080FF) begin failures++; $display("FAIL lhu: got %h want 000080ff", o.data); end
      run_access(1, 0, 3'b010, 32'h40, 32'h0, 5'd0, 1, 32'h11112222, o);
      checks++; if (o.rfw_total != 0) begin failures++; $display("FAIL rd0_no_write: got %0d writes want 0", o.rfw_total); end
   endtask

   task automatic test_store_sb;
      obs_t o;
      run_access(0, 1, 3'b000, 32'h11, 32'h000000A5, 5'd9, 1, 32'h0, o);
      checks++; if (o.bsel !== 4'b0010) begin failures++; $display("FAIL sb_sel: got %b want 0010", o.bsel); end
      checks++; if (o.bwdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o.bwdata); end
      checks++; if (o.wr_cyc != 1 || o.rd_cyc != 0 || o.rfw_total != 0) begin
         failures++; $display("FAIL sb_ctrl: got wr=%0d rd=%0d rfw=%0d want 1/0/0", o.wr_cyc, o.rd_cyc, o.rfw_total); end
   endtask

   task automatic test_fault;
      obs_t o;
      run_access(0, 1, 3'b001, 32'h13, 32'h5555, 5'd1, 1, 32'h0, o);
      checks++; if (o.fault_first !== 1'b1 || o.fault_total != 1) begin
         failures++; $display("FAIL sh_misaligned_fault: got first=%b total=%0d want 1/1", o.fault_first, o.fault_total); end
      checks++; if (o.stall_cyc != 0 || o.bus_cyc != 0) begin
         failures++; $display("FAIL sh_misaligned_quiet: got stall=%0d bus=%0d want 0/0", o.stall_cyc, o.bus_cyc); end
      run_access(1, 0, 3'b011, 32'h20, 32'h0, 5'd1, 1, 32'h0, o);
      checks++; if (o.fault_first !== 1'b1 || o.fault_total != 1 || o.stall_cyc != 0 || o.bus_cyc != 0) begin
         failures++; $display("FAIL illegal_load: got fault=%b/%0d stall=%0d bus=%0d want 1/1/0/0",
                              o.fault_first, o.fault_total, o.stall_cyc, o.bus_cyc); end
   endtask

   task automatic test_timeout;
      obs_t o;
      run_access(1, 0, 3'b010, 32'h300, 32'h0, 5'd3, 0, 32'h0, o);
      checks++; if (o.bus_cyc != TMO || o.stall_cyc != TMO + 1) begin
         failures++; $display("FAIL timeout_len: got bus=%0d stall=%0d want %0d/%0d", o.bus_cyc, o.stall_cyc, TMO, TMO + 1); end
      checks++; if (o.fault_done !== 1'b1 || o.fault_total != 1 || o.rfw_total != 0) begin
         failures++; $display("FAIL timeout_abort: got fault=%b/%0d rfw=%0d want 1/1/0", o.fault_done, o.fault_total, o.rfw_total); end
      run_access(1, 0, 3'b010, 32'h300, 32'h0, 5'd3, TMO, 32'hCAFEF00D, o);
      checks++; if (o.bus_cyc != TMO || o.fault_total != 0 || o.rfw_done !== 1'b1 || o.data !== 32'hCAFEF00D) begin
         failures++; $display("FAIL ack_at_expiry: got bus=%0d faults=%0d rfw=%b data=%h want %0d/0/1/cafef00d",
                              o.bus_cyc, o.fault_total, o.rfw_done, o.data, TMO); end
   endtask

   task automatic test_reset_midflight;
      int stray = 0;
      @(posedge clk); #1;
      load = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h500; rd = 5'd4; bus_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus_read !== 1'b1) begin failures++; $display("FAIL midflight_setup: got bus_read=%b want 1", bus_read); end
      #1 nRST = 1'b0;
      #1;
      checks++; if (bus_read !== 1'b0 || stall !== 1'b0) begin
         failures++; $display("FAIL async_drop: got bus_read=%b stall=%b want 0/0", bus_read, stall); end
      load = 1'b0;
      @(negedge clk);
      nRST = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rf_write || lsu_fault || bus_read || bus_write || stall) stray++;
      end
      checks++; if (stray != 0) begin failures++; $display("FAIL after_reset_quiet: got %0d active cycles want 0", stray); end
   endtask

   task automatic test_random;
      obs_t o;
      for (int it = 0; it < 60; it++) begin
         int          mode = $urandom_range(0, 2);
         bit          ld   = (mode != 1);
         bit          st   = (mode != 0);
         logic [2:0]  f3   = 3'($urandom_range(0, 7));
         logic [31:0] a    = $urandom;
         logic [31:0] sd   = $urandom;
         logic [4:0]  r    = 5'($urandom_range(0, 31));
         int          ack  = $urandom_range(0, 5);
         logic [31:0] rw   = $urandom;
         bit          ok;
         int          n;
         run_access(ld, st, f3, a, sd, r, ack, rw, o);
         checks++;
         if (o.timed_out) begin failures++; $display("FAIL rnd_hang it=%0d: access never completed", it); continue; end
         if (m_bad(ld, f3, a)) begin
            checks++;
            if (o.fault_first !== 1'b1 || o.fault_total != 1 || o.stall_cyc != 0 || o.bus_cyc != 0)
               begin failures++; $display("FAIL rnd_bad it=%0d f3=%0d a=%h: fault=%b/%0d stall=%0d bus=%0d want 1/1/0/0",
                                         it, f3, a, o.fault_first, o.fault_total, o.stall_cyc, o.bus_cyc); end
         end else begin
            ok = (ack >= 1 && ack <= TMO);
            n  = ok ? ack : TMO;
            checks++;
            if (o.bus_cyc != n || o.stall_cyc != n + 1 || o.rd_cyc != (ld ? n : 0) || o.unstable)
               begin failures++; $display("FAIL rnd_timing it=%0d: bus=%0d stall=%0d rd=%0d unstable=%b want %0d/%0d/%0d/0",
                                         it, o.bus_cyc, o.stall_cyc, o.rd_cyc, o.unstable, n, n + 1, ld ? n : 0); end
            checks++;
            if (o.baddr !== (a & 32'hFFFFFFFC) || o.bsel !== m_sel(ld, f3, a) || o.bwdata !== m_wdata(ld, f3, sd))
               begin failures++; $display("FAIL rnd_bus it=%0d: addr=%h sel=%b wdata=%h want %h/%b/%h",
                                         it, o.baddr, o.bsel, o.bwdata, a & 32'hFFFFFFFC, m_sel(ld, f3, a), m_wdata(ld, f3, sd)); end
            checks++;
            if (o.fault_total != (ok ? 0 : 1) || o.rfw_total != ((ok && ld && r != 0) ? 1 : 0))
               begin failures++; $display("FAIL rnd_result it=%0d: faults=%0d rfw=%0d want %0d/%0d",
                                         it, o.fault_total, o.rfw_total, ok ? 0 : 1, (ok && ld && r != 0) ? 1 : 0); end
            if (ok && ld && r != 0) begin
               checks++;
               if (o.idx !== r || o.data !== m_load(f3, a, rw))
                  begin failures++; $display("FAIL rnd_data it=%0d f3=%0d a=%h rw=%h: idx=%0d data=%h want %0d/%h",
                                            it, f3, a, rw, o.idx, o.data, r, m_load(f3, a, rw)); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store_sb();
      test_fault();
      test_timeout();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
